wash_cycle_controller: RTL and testbench

Top-level sequencer for the washing machine. Walks one wash programme through FILL, WASH, RINSE and SPIN, with an optional second wash/rinse pass. Owns the one-minute timer's control inputs (start point, mode) and treats each timer flag as one elapsed minute. Exposes phase, busy, minutes-left and done status to the panel/actuator logic.

---
 rtl/wash_cycle_controller_pkg.sv | 21 ++
 rtl/phase_minute_counter.sv | 33 +++
 rtl/wash_cycle_controller.sv | 128 ++++++++++++
 tb/tb_wash_cycle_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_cycle_controller_pkg.sv
// Shared encodings for the washing-machine control slice: programme phases,
// one-minute timer modes and the minute-counter width.
package wm_pkg;

  localparam int unsigned MIN_W = 4;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    TM_RUN   = 2'b00,
    TM_PAUSE = 2'b01,
    TM_STOP  = 2'b10
  } tmode_e;

endpackage

// File: rtl/phase_minute_counter.sv
// Minutes-remaining down-counter for the current wash phase, with a flag
// marking the final minute so the sequencer knows when to advance.
module phase_minute_counter
  import wm_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [MIN_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [MIN_W-1:0] o_count,
  output logic             o_last
);

  logic [MIN_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - MIN_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == MIN_W'(1));

endmodule

// File: rtl/wash_cycle_controller.sv
// Programme sequencer: FILL -> WASH -> RINSE [-> WASH -> RINSE] -> SPIN,
// counting one-minute timer flags only while the timer is in RUN.
module wash_cycle_controller
  import wm_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 20,
  parameter int unsigned FILL_MIN      = 2,
  parameter int unsigned WASH_MIN      = 5,
  parameter int unsigned RINSE_MIN     = 2,
  parameter int unsigned SPIN_MIN      = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             DoubleWash,
  input  logic             Pause,
  input  logic             TimerFlag,
  output logic [4:0]       TimerStartPoint,
  output logic [1:0]       TimerMode,
  output logic [2:0]       Phase,
  output logic [MIN_W-1:0] MinutesLeft,
  output logic             Busy,
  output logic             Done
);

  localparam logic [MIN_W-1:0] L_FILL  = MIN_W'(FILL_MIN);
  localparam logic [MIN_W-1:0] L_WASH  = MIN_W'(WASH_MIN);
  localparam logic [MIN_W-1:0] L_RINSE = MIN_W'(RINSE_MIN);
  localparam logic [MIN_W-1:0] L_SPIN  = MIN_W'(SPIN_MIN);

  phase_e           r_phase, w_phase_nx;
  tmode_e           r_mode, w_mode_nx;
  logic             r_second, w_second_nx;
  logic             r_done, w_done_nx;
  logic             w_ev, w_last, w_load, w_dec, w_clear;
  logic [MIN_W-1:0] w_load_val, w_count;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_phase  <= PH_IDLE;
      r_mode   <= TM_STOP;
      r_second <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_phase  <= w_phase_nx;
      r_mode   <= w_mode_nx;
      r_second <= w_second_nx;
      r_done   <= w_done_nx;
    end
  end

  // A held flag while paused must not count, so gate on the registered mode.
  assign w_ev = TimerFlag && (r_mode == TM_RUN);

  always_comb begin
    w_phase_nx  = r_phase;
    w_mode_nx   = r_mode;
    w_second_nx = r_second;
    w_done_nx   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    w_clear     = 1'b0;
    if (r_phase == PH_IDLE) begin
      w_mode_nx = TM_STOP;
      if (Start) begin
        w_phase_nx  = PH_FILL;
        w_load      = 1'b1;
        w_load_val  = L_FILL;
        w_mode_nx   = Pause ? TM_PAUSE : TM_RUN;
        w_second_nx = DoubleWash;
      end
    end else begin
      w_mode_nx = Pause ? TM_PAUSE : TM_RUN;
      if (w_ev && !w_last) begin
        w_dec = 1'b1;
      end else if (w_ev) begin
        w_load = 1'b1;
        case (r_phase)
          PH_FILL: begin
            w_phase_nx = PH_WASH;
            w_load_val = L_WASH;
          end
          PH_WASH: begin
            w_phase_nx = PH_RINSE;
            w_load_val = L_RINSE;
          end
          PH_RINSE: begin
            if (r_second) begin
              w_phase_nx  = PH_WASH;
              w_load_val  = L_WASH;
              w_second_nx = 1'b0;
            end else begin
              w_phase_nx = PH_SPIN;
              w_load_val = L_SPIN;
            end
          end
          default: begin
            w_phase_nx = PH_IDLE;
            w_load     = 1'b0;
            w_clear    = 1'b1;
            w_done_nx  = 1'b1;
            w_mode_nx  = TM_STOP;
          end
        endcase
      end
    end
  end

  phase_minute_counter u_minutes (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_last     (w_last)
  );

  assign TimerStartPoint = 5'(TICKS_PER_MIN);
  assign TimerMode       = r_mode;
  assign Phase           = r_phase;
  assign MinutesLeft     = w_count;
  assign Busy            = (r_phase != PH_IDLE);
  assign Done            = r_done;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller with a behavioural one-minute timer attached
// and a programme-list reference model.
module tb_wash_cycle_controller;

  localparam int TPM = 4, FM = 1, WM = 2, RM = 1, SM = 1;

  logic       CLK = 1'b0, RST = 1'b0, Start = 1'b0, DoubleWash = 1'b0, Pause = 1'b0;
  logic       TimerFlag;
  logic [4:0] TimerStartPoint;
  logic [1:0] TimerMode;
  logic [2:0] Phase;
  logic [3:0] MinutesLeft;
  logic       Busy, Done;

  int n_checks = 0, n_pass = 0;

  wash_cycle_controller #(
    .TICKS_PER_MIN (TPM), .FILL_MIN (FM), .WASH_MIN (WM), .RINSE_MIN (RM), .SPIN_MIN (SM)
  ) dut (
    .CLK (CLK), .RST (RST), .Start (Start), .DoubleWash (DoubleWash), .Pause (Pause),
    .TimerFlag (TimerFlag), .TimerStartPoint (TimerStartPoint), .TimerMode (TimerMode),
    .Phase (Phase), .MinutesLeft (MinutesLeft), .Busy (Busy), .Done (Done)
  );

  always #5 CLK = ~CLK;

  // Timer: loads start-1 while stopped, flags at zero, reloads to start in RUN, holds in PAUSE.
  logic [4:0] t_cnt = '0;
  always @(posedge CLK) begin
    if (TimerMode === 2'b00)      t_cnt <= (t_cnt == 5'd0) ? TimerStartPoint : t_cnt - 5'd1;
    else if (TimerMode !== 2'b01) t_cnt <= TimerStartPoint - 5'd1;
  end
  assign TimerFlag = (t_cnt == 5'd0) && (TimerMode === 2'b00 || TimerMode === 2'b01);

  // Reference model: a list of phases for the programme, minutes left, timer mode.
  int m_plan[$];
  int m_idx = 0, m_left = 0, m_mode = 2;
  bit m_done = 0;

  function automatic int dur(input int p);
    case (p)
      1: return FM;
      2: return WM;
      3: return RM;
      default: return SM;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec();
    int ph;
    ph = (m_plan.size() == 0) ? 0 : m_plan[m_idx];
    return {3'(ph), 4'(m_left), 2'(m_mode), m_done, (ph != 0)};
  endfunction

  logic [10:0] dut_vec;
  assign dut_vec = {Phase, MinutesLeft, TimerMode, Done, Busy};

  task automatic model_edge();
    if (!RST) begin
      m_plan.delete(); m_idx = 0; m_left = 0; m_mode = 2; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_plan.size() == 0) begin
      m_mode = 2;
      if (Start) begin
        m_plan = {1, 2, 3};
        if (DoubleWash) m_plan = {m_plan, 2, 3};
        m_plan.push_back(4);
        m_idx = 0; m_left = dur(1); m_mode = Pause ? 1 : 0;
      end
    end else begin
      if (TimerFlag && m_mode == 0) begin
        if (m_left > 1) m_left--;
        else begin
          m_idx++;
          if (m_idx == m_plan.size()) begin
            m_plan.delete(); m_idx = 0; m_left = 0; m_done = 1;
          end else m_left = dur(m_plan[m_idx]);
        end
      end
      m_mode = (m_plan.size() == 0) ? 2 : (Pause ? 1 : 0);
    end
  endtask

  // Inputs are driven at the falling edge; the model advances from those, then outputs are sampled there.
  task automatic tick();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 0; Start = 1; Pause = 0;
    repeat (3) tick();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_vec: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    n_checks++;
    if ({Phase, TimerMode, MinutesLeft, Done, Busy} !== {3'd0, 2'b10, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: got ph=%0d mode=%b left=%0d done=%b", Phase, TimerMode, MinutesLeft, Done);
    else n_pass++;
    n_checks++;
    if (TimerStartPoint !== 5'd4) $display("FAIL start_point: got %0d expected 4", TimerStartPoint);
    else n_pass++;
    Start = 0; RST = 1;
    tick();
  endtask

  task automatic test_programme(input bit dw);
    int run, dones, bad, exp_run, m;
    int seq[$], exp_seq[$];
    bit saw_w2, saw_w1;
    run = 0; dones = 0; bad = 0; saw_w2 = 0; saw_w1 = 0;
    Start = 1; DoubleWash = dw; tick();
    Start = 0; DoubleWash = 1'($urandom);
    seq.push_back(int'(Phase));
    for (int c = 0; c < 300; c++) begin
      if (TimerMode == 2'b00) run++;
      tick();
      if (dut_vec !== exp_vec()) bad++;
      if (Done) dones++;
      if (Phase == 3'd2 && MinutesLeft == 4'd2) saw_w2 = 1;
      if (Phase == 3'd2 && MinutesLeft == 4'd1 && saw_w2) saw_w1 = 1;
      if (int'(Phase) != seq[$]) seq.push_back(int'(Phase));
      if (Phase == 3'd0) break;
    end
    m = FM + WM + RM + SM + (dw ? WM + RM : 0);
    exp_run = TPM + (m - 1) * (TPM + 1);
    exp_seq = dw ? '{1, 2, 3, 2, 3, 4, 0} : '{1, 2, 3, 4, 0};
    n_checks++;
    if (bad != 0) $display("FAIL prog_trace dw=%0d: %0d cycles differ from model", dw, bad);
    else n_pass++;
    n_checks++;
    if (run != exp_run) $display("FAIL prog_length dw=%0d: got %0d run cycles expected %0d", dw, run, exp_run);
    else n_pass++;
    n_checks++;
    if (dones != 1 || Done !== 1'b1) $display("FAIL prog_done dw=%0d: got %0d pulses (done=%b) expected 1", dw, dones, Done);
    else n_pass++;
    n_checks++;
    if (seq != exp_seq) $display("FAIL prog_phases dw=%0d: got %p expected %p", dw, seq, exp_seq);
    else n_pass++;
    n_checks++;
    if (!saw_w1) $display("FAIL wash_minutes dw=%0d: got no 2->1 in WASH expected 1", dw);
    else n_pass++;
    tick();
  endtask

  task automatic test_pause();
    int c, left0, bad;
    bad = 0;
    Start = 1; DoubleWash = 0; tick(); Start = 0;
    for (c = 0; c < 100; c++) begin
      if (Phase == 3'd2 && MinutesLeft == 4'd2 && t_cnt == 5'd1 && TimerMode == 2'b00) break;
      tick();
    end
    n_checks++;
    if (c == 100) $display("FAIL pause_reach: got timeout expected WASH count 1");
    else n_pass++;
    left0 = int'(MinutesLeft);
    Pause = 1;
    repeat (10) begin
      tick();
      if (dut_vec !== exp_vec() || TimerMode !== 2'b01 || int'(MinutesLeft) != left0 || TimerFlag !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL pause_hold: got %0d bad cycles (mode=%b left=%0d) expected 0", bad, TimerMode, MinutesLeft);
    else n_pass++;
    Pause = 0;
    tick(); tick();
    n_checks++;
    if (int'(MinutesLeft) != left0 - 1 || Phase !== 3'd2) $display("FAIL pause_release: got left=%0d ph=%0d expected %0d/2", MinutesLeft, Phase, left0 - 1);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL pause_after: got %h expected %h", dut_vec, exp_vec());
    else n_pass++;
    for (c = 0; c < 100 && Phase != 3'd0; c++) tick();
    tick();
  endtask

  task automatic test_start_ignored();
    int c, bad;
    bad = 0;
    Start = 1; DoubleWash = 0; tick();
    for (c = 0; c < 200; c++) begin
      Start = (Phase == 3'd4) ? 1'b1 : ((Phase == 3'd1) ? 1'($urandom) : 1'b0);
      DoubleWash = 1'($urandom);
      tick();
      if (dut_vec !== exp_vec()) bad++;
      if (Done) break;
    end
    n_checks++;
    if (bad != 0 || c == 200) $display("FAIL start_busy: got %0d bad cycles (timeout=%0d) expected 0", bad, c == 200);
    else n_pass++;
    n_checks++;
    if (Phase !== 3'd0 || Done !== 1'b1) $display("FAIL done_idle: got ph=%0d done=%b expected 0/1", Phase, Done);
    else n_pass++;
    tick();
    n_checks++;
    if (Phase !== 3'd1 || Done !== 1'b0 || dut_vec !== exp_vec()) $display("FAIL restart: got ph=%0d done=%b expected 1/0", Phase, Done);
    else n_pass++;
    Start = 0;
  endtask

  task automatic test_coincident();
    int c;
    RST = 0; tick(); RST = 1; tick();
    Start = 1; DoubleWash = 0; tick(); Start = 0;
    for (c = 0; c < 100; c++) begin
      if (Phase == 3'd3 && TimerFlag && TimerMode == 2'b00) break;
      tick();
    end
    Pause = 1; tick();
    n_checks++;
    if (c == 100 || Phase !== 3'd4 || TimerMode !== 2'b01 || MinutesLeft !== 4'd1)
      $display("FAIL coincident: got ph=%0d mode=%b left=%0d expected 4/01/1", Phase, TimerMode, MinutesLeft);
    else n_pass++;
    Pause = 0;
    for (c = 0; c < 100 && Phase != 3'd0; c++) tick();
    tick();
  endtask

  task automatic test_reset_midwash();
    int c, dones;
    dones = 0;
    Start = 1; DoubleWash = 1'($urandom); tick(); Start = 0;
    for (c = 0; c < 100 && Phase != 3'd2; c++) tick();
    repeat ($urandom_range(0, 3)) tick();
    RST = 0; tick(); RST = 1;
    n_checks++;
    if (c == 100 || {Phase, TimerMode, MinutesLeft, Done} !== {3'd0, 2'b10, 4'd0, 1'b0})
      $display("FAIL reset_midwash: got ph=%0d mode=%b left=%0d done=%b", Phase, TimerMode, MinutesLeft, Done);
    else n_pass++;
    repeat (30) begin
      tick();
      if (Done) dones++;
    end
    n_checks++;
    if (dones != 0 || dut_vec !== exp_vec()) $display("FAIL reset_nodone: got %0d pulses expected 0", dones);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      Start = ($urandom_range(0, 9) == 0);
      Pause = ($urandom_range(0, 5) == 0);
      DoubleWash = 1'($urandom);
      RST = ($urandom_range(0, 199) != 0);
      tick();
      if (dut_vec !== exp_vec()) begin
        bad++;
        if (bad < 4) $display("FAIL random_cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL random: got %0d bad cycles expected 0", bad);
    else n_pass++;
    RST = 1; Start = 0; Pause = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_programme(1'b0);
    test_programme(1'b1);
    test_pause();
    test_start_ignored();
    test_coincident();
    test_reset_midwash();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
